// File: rtl/lw_sha_msg_scheduler.sv
// rtl/lw_sha_msg_scheduler.sv - SHA-256/SHA-512 message schedule generator.
// Loads 16 message words, then streams W[0..R-1] with a rolling 16-entry buffer.
module lw_sha_msg_scheduler #(
   parameter int WORD_W     = 64,
   parameter int ROUNDS_256 = 64,
   parameter int ROUNDS_512 = 80
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_word,
   output logic [6:0]        out_round,
   output logic              out_last,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND} state_t;

   state_t            state_q, state_d;
   logic [3:0]        load_cnt_q;
   logic [6:0]        t_q;
   logic              mode_q;
   logic [WORD_W-1:0] buf_q [16];

   logic [6:0]        r_last;
   logic              at_last;
   logic [3:0]        idx2, idx7, idx15, idx16;
   logic [63:0]       w2, w7, w15, w16;
   logic [31:0]       s0_32, s1_32, sum32;
   logic [63:0]       s0_64, s1_64, sum64, expanded;

   assign r_last  = mode_q ? 7'(ROUNDS_512 - 1) : 7'(ROUNDS_256 - 1);
   assign at_last = (t_q == r_last);

   // 4-bit index arithmetic gives the mod-16 wrap of the rolling buffer for free
   assign idx16 = t_q[3:0];
   assign idx2  = t_q[3:0] - 4'd2;
   assign idx7  = t_q[3:0] - 4'd7;
   assign idx15 = t_q[3:0] - 4'd15;

   assign w2  = 64'(buf_q[idx2]);
   assign w7  = 64'(buf_q[idx7]);
   assign w15 = 64'(buf_q[idx15]);
   assign w16 = 64'(buf_q[idx16]);

   assign s0_32 = {w15[6:0], w15[31:7]} ^ {w15[17:0], w15[31:18]} ^ (w15[31:0] >> 3);
   assign s1_32 = {w2[16:0], w2[31:17]} ^ {w2[18:0], w2[31:19]} ^ (w2[31:0] >> 10);
   assign sum32 = s1_32 + w7[31:0] + s0_32 + w16[31:0];

   assign s0_64 = {w15[0], w15[63:1]} ^ {w15[7:0], w15[63:8]} ^ (w15 >> 7);
   assign s1_64 = {w2[18:0], w2[63:19]} ^ {w2[60:0], w2[63:61]} ^ (w2 >> 6);
   assign sum64 = s1_64 + w7 + s0_64 + w16;

   assign expanded = mode_q ? sum64 : {32'd0, sum32};
   assign out_word  = (t_q < 7'd16) ? buf_q[idx16] : expanded[WORD_W-1:0];
   assign out_round = t_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_LOAD;
         S_LOAD: begin
            if (abort)                                state_d = S_IDLE;
            else if (in_valid && load_cnt_q == 4'd15) state_d = S_EXPAND;
         end
         S_EXPAND: begin
            if (abort)                     state_d = S_IDLE;
            else if (out_ready && at_last) state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_LOAD);
      out_valid = (state_q == S_EXPAND);
      out_last  = (state_q == S_EXPAND) && at_last;
      busy      = (state_q != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_cnt_q <= 4'd0;
         t_q        <= 7'd0;
         mode_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q     <= (WORD_W == 64) ? mode : 1'b0;
                  load_cnt_q <= 4'd0;
                  t_q        <= 7'd0;
               end
            end
            S_LOAD: begin
               if (abort)         load_cnt_q <= 4'd0;
               else if (in_valid) load_cnt_q <= load_cnt_q + 4'd1;
            end
            S_EXPAND: begin
               if (abort || (out_ready && at_last)) t_q <= 7'd0;
               else if (out_ready)                  t_q <= t_q + 7'd1;
            end
            default: ;
         endcase
      end
   end

   // Buffer is not reset; its content only matters after a full LOAD
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD && !abort && in_valid)
         buf_q[load_cnt_q] <= in_word;
      else if (state_q == S_EXPAND && !abort && out_ready)
         buf_q[idx16] <= out_word;
   end

endmodule
